alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Sequencing front-end for the 16-bit combinational ALU; the initiator side of the ALU interface.
//  Accepts op requests over valid/ready and drives registered alu_ctrl/alu_a/alu_b.
//  Captures alu_out plus locally computed Z/V/N flags, then returns the result over valid/ready.
//  Holds the architectural flags register and evaluates branch conditions from it.
// PARAMETERS
//  WIDTH    16  datapath width (ALU is 16; other values unsupported)
//  RD_W     3   destination-register tag width
//  CMP_RSP  0   1: CMP also returns a response beat; 0: CMP updates flags only
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous reset, active-low
//  req_valid     in   1      request present
//  req_ready     out  1      request accepted when valid&ready
//  req_op        in   3      1 AND, 2 ADD, 3 SUB, 4 SLL, 5 SRL, 6 CMP, 0/7 illegal
//  req_a,req_b   in   WIDTH  signed operands
//  req_rd        in   RD_W   destination tag
//  alu_ctrl      out  3      to ALU
//  alu_a,alu_b   out  WIDTH  to ALU
//  alu_out       in   WIDTH  ALU result
//  alu_zero,alu_overflow,alu_neg  in  1 each; ALU flags (checked only, not used)
//  rsp_valid     out  1      result beat valid
//  rsp_ready     in   1      consumer accepts beat
//  rsp_data      out  WIDTH  result
//  rsp_rd        out  RD_W   echoed tag
//  rsp_err       out  1      illegal op
//  flag_z,flag_v,flag_n  out  1  architectural flags
//  br_cond       in   2      00 EQ(Z), 01 NE(!Z), 10 LT(N^V), 11 GE(!(N^V))
//  br_taken      out  1      combinational from flag regs and br_cond
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all registered outputs and flags = 0; req_ready=0 during reset.
//  FSM: IDLE -> EXEC on req_valid&req_ready.
//       EXEC -> RESP when a response beat is produced.
//       EXEC -> IDLE for CMP when CMP_RSP=0.
//       RESP -> IDLE on rsp_valid&rsp_ready.
//  req_ready = (state==IDLE). One op in flight; no overlap.
//  Accept edge (cycle 0): latch op, rd, a, b. Drive alu_a=a and alu_b=b unchanged (ALU shifts by b[3:0]).
//   alu_ctrl = op for ops 1..5; 3 for CMP; 0 for illegal ops.
//  In IDLE/RESP: alu_ctrl=0, alu_a/alu_b hold their last values.
//  End of EXEC (cycle 1): capture rsp_data=alu_out and rsp_err=(op illegal). rsp_valid rises in cycle 2.
//   Best-case issue interval is 3 cycles.
//  Flags are computed locally from the latched operands and alu_out (r = result sign bit):
//   ADD: V = (a15==b15) & (r!=a15).
//   SUB/CMP: V = (a15!=b15) & (r!=a15).
//   AND/SLL/SRL: V = 0.
//   Z = (alu_out==0); N = r.
//   Flags update at end of EXEC for ops 1..6. Illegal op: flags unchanged, rsp_data=0, rsp_err=1.
//  RESP: rsp_data, rsp_rd, rsp_err held stable while rsp_valid=1 & !rsp_ready. rsp_valid never drops without handshake.
//  br_taken uses registered flags. In the cycle flags update, br_taken shows the pre-update value.
//  Reset mid-EXEC/RESP aborts the op: no beat is emitted, flags = 0.
//  Assertion: on ADD, alu_overflow == locally computed V; alu_zero == Z for all legal ops.
// STRUCTURE
//  Shared package alu_pkg: op encodings (OP_AND=1, OP_ADD=2, OP_SUB=3, OP_SLL=4, OP_SRL=5, OP_CMP=6),
//   br_cond encodings, FSM state encodings.
//  One sub-module alu_flag_unit: combinational Z/V/N computation plus br_taken mux. The rest is the FSM and registers.
// TESTING
//  1 ADD a=10 b=5, rsp_ready=1 -> rsp_valid in cycle 2, rsp_data=15, Z=0 N=0 V=0, req_ready high in cycle 3.
//  2 ADD a=32767 b=1 -> rsp_data=0x8000, N=1 V=1; br_cond=10 -> br_taken=0 (N^V=0).
//  3 SUB a=20 b=30 -> rsp_data=0xFFF6 (-10), N=1 V=0; br_cond=10 -> br_taken=1.
//  4 CMP a=5 b=5, CMP_RSP=0 -> no rsp beat, Z=1; br_cond=00 -> br_taken=1; req_ready back after 2 cycles.
//  5 SLL a=0x0F0F b=4 with rsp_ready=0 for 3 cycles -> rsp_data=0xF0F0 held stable, req_ready=0, V=0.
//    Next request is accepted the cycle after the handshake.
//  6 Illegal op=7 -> rsp_err=1, rsp_data=0, flags unchanged.
//    Separately: rst_n low during EXEC -> IDLE, no beat, all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: op codes, branch conditions, FSM states.
// Combinational helpers only; no latency, no flow control.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [2:0] {
    OP_ILL0 = 3'd0,
    OP_AND  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_SLL  = 3'd4,
    OP_SRL  = 3'd5,
    OP_CMP  = 3'd6,
    OP_ILL7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } br_cond_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op != OP_ILL0) && (op != OP_ILL7);
  endfunction

  // CMP is a subtract whose result is discarded; illegal ops park the ALU on code 0.
  function automatic logic [2:0] alu_ctrl_of(input logic [2:0] op);
    logic [2:0] ctrl;
    ctrl = 3'd0;
    if (op_legal(op)) begin
      ctrl = (op == OP_CMP) ? OP_SUB : op;
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_flag_unit.sv
// Combinational Z/V/N derivation from latched operands and ALU result, plus branch condition mux.
// Zero latency; no flow control.
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r,
  input  logic [1:0]       br_cond,
  input  logic             flag_z,
  input  logic             flag_v,
  input  logic             flag_n,
  output logic             z_d,
  output logic             v_d,
  output logic             n_d,
  output logic             br_taken
);

  logic a_s, b_s, r_s;

  assign a_s = a[WIDTH-1];
  assign b_s = b[WIDTH-1];
  assign r_s = r[WIDTH-1];

  always_comb begin
    z_d = (r == '0);
    n_d = r_s;
    v_d = 1'b0;
    case (op)
      OP_ADD:         v_d = (a_s == b_s) && (r_s != a_s);
      OP_SUB, OP_CMP: v_d = (a_s != b_s) && (r_s != a_s);
      default:        v_d = 1'b0;
    endcase
  end

  // Branches look only at the architectural registers, never at the in-flight result.
  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      BR_EQ:   br_taken = flag_z;
      BR_NE:   br_taken = !flag_z;
      BR_LT:   br_taken = flag_n ^ flag_v;
      BR_GE:   br_taken = !(flag_n ^ flag_v);
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue front-end for the combinational ALU: one op in flight, result beat two cycles after accept.
// req_ready only in IDLE; response beat held stable until rsp_ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int RD_W    = 3,
  parameter bit CMP_RSP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [RD_W-1:0]  req_rd,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_neg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [RD_W-1:0]  rsp_rd,
  output logic             rsp_err,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  input  logic [1:0]       br_cond,
  output logic             br_taken
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [RD_W-1:0]  rsp_rd_q, rsp_rd_d;
  logic             rsp_err_q, rsp_err_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_v_q, flag_v_d;
  logic             flag_n_q, flag_n_d;

  logic             flg_z, flg_v, flg_n;
  logic             accept;

  alu_flag_unit #(.WIDTH(WIDTH)) u_flag_unit (
    .op       (op_q),
    .a        (alu_a_q),
    .b        (alu_b_q),
    .r        (alu_out),
    .br_cond  (br_cond),
    .flag_z   (flag_z_q),
    .flag_v   (flag_v_q),
    .flag_n   (flag_n_q),
    .z_d      (flg_z),
    .v_d      (flg_v),
    .n_d      (flg_n),
    .br_taken (br_taken)
  );

  // Gating with rst_n keeps ready low for the whole reset window, not just after the first edge.
  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    alu_ctrl_d  = 3'd0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_err_d   = rsp_err_q;
    flag_z_d    = flag_z_q;
    flag_v_d    = flag_v_q;
    flag_n_d    = flag_n_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = req_op;
          rd_d       = req_rd;
          alu_a_d    = req_a;
          alu_b_d    = req_b;
          alu_ctrl_d = alu_ctrl_of(req_op);
          state_d    = S_EXEC;
        end
      end

      S_EXEC: begin
        if (!op_legal(op_q)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_rd_d    = rd_q;
          state_d     = S_RESP;
        end else begin
          flag_z_d = flg_z;
          flag_v_d = flg_v;
          flag_n_d = flg_n;
          if ((op_q == OP_CMP) && !CMP_RSP) begin
            state_d = S_IDLE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_out;
            rsp_err_d   = 1'b0;
            rsp_rd_d    = rd_q;
            state_d     = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      rd_q        <= '0;
      alu_ctrl_q  <= 3'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_n_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
      flag_z_q    <= flag_z_d;
      flag_v_q    <= flag_v_d;
      flag_n_q    <= flag_n_d;
    end
  end

  assign alu_ctrl  = alu_ctrl_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_err   = rsp_err_q;
  assign flag_z    = flag_z_q;
  assign flag_v    = flag_v_q;
  assign flag_n    = flag_n_q;

  // Cross-check the locally derived flags against the ALU's own view while the op executes.
  a_add_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_EXEC && op_q == OP_ADD) |-> (alu_overflow == flg_v));
  a_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_EXEC && op_legal(op_q)) |-> (alu_zero == flg_z));
  a_neg: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_EXEC && op_legal(op_q)) |-> (alu_neg == flg_n));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural 16-bit ALU and a queue-based response scoreboard.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [2:0]  req_rd;
  logic [2:0]  alu_ctrl;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_zero, alu_overflow, alu_neg;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_err;
  logic        flag_z, flag_v, flag_n;
  logic [1:0]  br_cond;
  logic        br_taken;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_beats  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(16), .RD_W(3), .CMP_RSP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .br_cond(br_cond), .br_taken(br_taken)
  );

  // Behavioural ALU the controller drives.
  always_comb begin
    alu_out      = 16'h0000;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      3'd1: alu_out = alu_a & alu_b;
      3'd2: begin
        alu_out      = alu_a + alu_b;
        alu_overflow = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      3'd3: begin
        alu_out      = alu_a - alu_b;
        alu_overflow = (alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      3'd4: alu_out = alu_a << alu_b[3:0];
      3'd5: alu_out = alu_a >> alu_b[3:0];
      default: alu_out = 16'h0000;
    endcase
    alu_zero = (alu_out == 16'h0000);
    alu_neg  = alu_out[15];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard monitor: every cycle a beat is presented it must match the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_rsp_beat");
      end else begin
        check("rsp_data", rsp_data, exp_q[0].data);
        check("rsp_rd", rsp_rd, exp_q[0].rd);
        check("rsp_err", rsp_err, exp_q[0].err);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          n_beats++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge (EXEC).
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] rd, input bit push, input logic [15:0] exp_data,
                      input logic exp_err, output int waited);
    rsp_t e;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) fail("req_ready_timeout");
    if (push) begin
      e.data = exp_data;
      e.rd   = rd;
      e.err  = exp_err;
      exp_q.push_back(e);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    req_valid = 1'b0; req_op = 3'd0; req_a = 16'h0; req_b = 16'h0; req_rd = 3'd0;
    rsp_ready = 1'b1; br_cond = 2'b00;

    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_flags", {flag_z, flag_v, flag_n}, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    #10 rst_n = 1'b1;
    step();

    // 1: ADD 10+5
    send(OP_ADD, 16'd10, 16'd5, 3'd1, 1'b1, 16'd15, 1'b0, w);
    check("t1_c1_rsp_valid", rsp_valid, 0);
    check("t1_c1_req_ready", req_ready, 0);
    check("t1_alu_ctrl", alu_ctrl, 2);
    check("t1_alu_a", alu_a, 10);
    check("t1_alu_b", alu_b, 5);
    step();
    check("t1_c2_rsp_valid", rsp_valid, 1);
    check("t1_flags_zvn", {flag_z, flag_v, flag_n}, 3'b000);
    step();
    check("t1_c3_req_ready", req_ready, 1);
    check("t1_c3_rsp_valid", rsp_valid, 0);

    // 2: ADD 32767+1 overflows
    send(OP_ADD, 16'd32767, 16'd1, 3'd2, 1'b1, 16'h8000, 1'b0, w);
    step();
    check("t2_flags_zvn", {flag_z, flag_v, flag_n}, 3'b011);
    br_cond = 2'b10; #1;
    check("t2_br_lt", br_taken, 0);
    br_cond = 2'b11; #1;
    check("t2_br_ge", br_taken, 1);
    step();

    // 3: SUB 20-30; LT still reflects previous flags during EXEC
    br_cond = 2'b10;
    send(OP_SUB, 16'd20, 16'd30, 3'd3, 1'b1, 16'hFFF6, 1'b0, w);
    check("t3_br_pre_update", br_taken, 0);
    step();
    check("t3_flags_zvn", {flag_z, flag_v, flag_n}, 3'b001);
    check("t3_br_lt", br_taken, 1);
    step();

    // 4: CMP 5,5 - flags only, no beat
    send(OP_CMP, 16'd5, 16'd5, 3'd4, 1'b0, 16'h0, 1'b0, w);
    check("t4_alu_ctrl", alu_ctrl, 3);
    step();
    check("t4_req_ready", req_ready, 1);
    check("t4_rsp_valid", rsp_valid, 0);
    check("t4_flags_zvn", {flag_z, flag_v, flag_n}, 3'b100);
    br_cond = 2'b00; #1;
    check("t4_br_eq", br_taken, 1);

    // 5: SLL with 3 cycles of backpressure
    rsp_ready = 1'b0;
    send(OP_SLL, 16'h0F0F, 16'd4, 3'd5, 1'b1, 16'hF0F0, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_hold_rsp_valid", rsp_valid, 1);
      check("t5_hold_req_ready", req_ready, 0);
    end
    check("t5_flags_zvn", {flag_z, flag_v, flag_n}, 3'b001);
    step();
    rsp_ready = 1'b1;
    step();
    check("t5_req_ready_after_hs", req_ready, 1);
    send(OP_SRL, 16'hF000, 16'h0014, 3'd6, 1'b1, 16'h0F00, 1'b0, w);
    check("t5_accept_wait", w, 0);
    check("srl_alu_b_unchanged", alu_b, 16'h0014);
    step();
    step();
    send(OP_AND, 16'h00F0, 16'h0F0F, 3'd7, 1'b1, 16'h0000, 1'b0, w);
    step();
    check("and_flags_zvn", {flag_z, flag_v, flag_n}, 3'b100);
    step();

    // 6: illegal ops leave flags alone
    send(OP_ILL7, 16'h1234, 16'h5678, 3'd2, 1'b1, 16'h0000, 1'b1, w);
    check("ill7_alu_ctrl", alu_ctrl, 0);
    step();
    check("ill7_flags_zvn", {flag_z, flag_v, flag_n}, 3'b100);
    step();
    send(OP_ILL0, 16'hFFFF, 16'h0001, 3'd3, 1'b1, 16'h0000, 1'b1, w);
    step();
    check("ill0_flags_zvn", {flag_z, flag_v, flag_n}, 3'b100);
    step();

    // Reset during EXEC aborts the op
    send(OP_ADD, 16'd1, 16'd1, 3'd1, 1'b0, 16'h0, 1'b0, w);
    rst_n = 1'b0; #1;
    check("rst_exec_rsp_valid", rsp_valid, 0);
    check("rst_exec_req_ready", req_ready, 0);
    check("rst_exec_flags", {flag_z, flag_v, flag_n}, 0);
    check("rst_exec_alu_ctrl", alu_ctrl, 0);
    check("rst_exec_alu_a", alu_a, 0);
    check("rst_exec_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("beats_seen", n_beats, 8);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
